// File: rtl/regfile_seq_pkg.sv
// Shared opcodes, FSM state encoding and default geometry for the register-file sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Zero-protect build option REGFILE_SEQ_ZERO_PROTECT_EN is consumed by regfile_sequencer.
package regfile_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREGS_DEF  = 32;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ2 = 3'd2;
    localparam logic [2:0] OP_COPY  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;
    localparam logic [2:0] OP_DUMP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD       = 3'd2,
        S_RSP      = 3'd3,
        S_CPY_WR   = 3'd4,
        S_CLR      = 3'd5,
        S_DUMP_RD  = 3'd6,
        S_DUMP_RSP = 3'd7
    } state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Command-driven master for the 32-entry register file: WRITE, READ2, COPY, CLEAR, DUMP.
// Latency: WRITE 1 cycle, READ2/DUMP 1 read cycle then response, COPY 2, CLEAR NREGS (NREGS-1 protected).
// Backpressure: cmd_ready only in IDLE; responses held until rsp_ready. Option: REGFILE_SEQ_ZERO_PROTECT_EN.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_err,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2
);

`ifdef REGFILE_SEQ_ZERO_PROTECT_EN
    localparam bit ZERO_PROTECT = 1'b1;
`else
    localparam bit ZERO_PROTECT = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] CLR_FIRST = ZERO_PROTECT ? ADDR_W'(1) : '0;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   cap1_q, cap1_d;
    logic [DATA_W-1:0]   cap2_q, cap2_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_NOP;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_q   <= '0;
            cap1_q   <= '0;
            cap2_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_q   <= data_d;
            cap1_q   <= cap1_d;
            cap2_q   <= cap2_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_d   = data_q;
        cap1_d   = cap1_q;
        cap2_d   = cap2_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    addr_a_d = cmd_addr_a;
                    addr_b_d = cmd_addr_b;
                    data_d   = cmd_data;
                    case (cmd_op)
                        OP_NOP:   state_d = S_IDLE;
                        OP_WRITE: state_d = S_WR;
                        OP_READ2,
                        OP_COPY:  state_d = S_RD;
                        OP_CLEAR: begin
                            cnt_d   = CLR_FIRST;
                            state_d = S_CLR;
                        end
                        OP_DUMP: begin
                            cnt_d   = '0;
                            state_d = S_DUMP_RD;
                        end
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            S_WR:     state_d = S_IDLE;
            S_RD: begin
                cap1_d  = rf_rdata1;
                cap2_d  = rf_rdata2;
                state_d = (op_q == OP_COPY) ? S_CPY_WR : S_RSP;
            end
            S_RSP:    if (rsp_ready) state_d = S_IDLE;
            S_CPY_WR: state_d = S_IDLE;
            S_CLR: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_DUMP_RD: begin
                cap1_d  = rf_rdata1;
                cap2_d  = rf_rdata2;
                state_d = S_DUMP_RSP;
            end
            S_DUMP_RSP: begin
                if (rsp_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = S_DUMP_RD;
                    end
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Reads and writes never share a cycle: the register file blanks rdata while we=1.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        rsp_valid = 1'b0;
        rsp_addr  = '0;
        case (state_q)
            S_WR: begin
                rf_we    = !(ZERO_PROTECT && (addr_a_q == '0));
                rf_waddr = addr_a_q;
                rf_wdata = data_q;
            end
            S_CPY_WR: begin
                rf_we    = !(ZERO_PROTECT && (addr_b_q == '0));
                rf_waddr = addr_b_q;
                rf_wdata = cap1_q;
            end
            S_CLR: begin
                rf_we    = 1'b1;
                rf_waddr = cnt_q;
            end
            S_RD: begin
                rf_raddr1 = addr_a_q;
                rf_raddr2 = addr_b_q;
            end
            S_DUMP_RD: begin
                rf_raddr1 = cnt_q;
                rf_raddr2 = cnt_q;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_addr  = addr_a_q;
            end
            S_DUMP_RSP: begin
                rsp_valid = 1'b1;
                rsp_addr  = cnt_q;
            end
            default: ;
        endcase
    end

    assign cmd_err   = err_q;
    assign rsp_data1 = cap1_q;
    assign rsp_data2 = cap2_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer driving a behavioural 32-entry register file; honours REGFILE_SEQ_ZERO_PROTECT_EN.
// Directed table, multi-cycle corner sequences, then random commands against an array-level reference model.
module tb_regfile_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

`ifdef REGFILE_SEQ_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    localparam logic [2:0] C_NOP = 3'd0, C_WRITE = 3'd1, C_READ2 = 3'd2,
                           C_COPY = 3'd3, C_CLEAR = 3'd4, C_DUMP = 3'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_addr_a = '0;
    logic [AW-1:0] cmd_addr_b = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_err;
    logic          rf_we;
    logic [AW-1:0] rf_waddr, rf_raddr1, rf_raddr2;
    logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data1, rsp_data2;

    logic [DW-1:0] rf_mem [NR] = '{default: '0};
    logic [DW-1:0] model  [NR] = '{default: '0};

    int vec_cnt = 0;
    int err_cnt = 0;
    int we_cnt  = 0;
    int rsp_cnt = 0;

    regfile_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
        .cmd_err(cmd_err),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, combinational read blanked during writes.
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    assign rf_rdata1 = rf_we ? '0 : rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_we ? '0 : rf_mem[rf_raddr2];

    always @(posedge clk) begin
        if (rf_we) we_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Response hold monitor: once offered, valid/addr/data stay put until a ready edge.
    logic          rdy_at_edge = 1'b0;
    logic          pv = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd1 = '0, pd2 = '0;
    always @(posedge clk) rdy_at_edge = rsp_ready;
    always @(negedge clk) begin
        if (!rst && pv && !rdy_at_edge) begin
            chk("rsp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rsp_hold_bits", {rsp_addr, rsp_data1 ^ rsp_data2 ^ rsp_data1}, {pa, pd2});
        end
        pv  = rsp_valid;
        pa  = rsp_addr;
        pd1 = rsp_data1;
        pd2 = rsp_data2;
    end

    task automatic model_apply(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic [DW-1:0] d);
        case (op)
            C_WRITE: if (!(ZP && a == 0)) model[a] = d;
            C_COPY:  if (!(ZP && b == 0)) model[b] = model[a];
            C_CLEAR: for (int i = (ZP ? 1 : 0); i < NR; i++) model[i] = '0;
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Returns at posedge+1 of the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d);
        wait_idle();
        cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = C_NOP;
    endtask

    task automatic get_rsp(input string nm, input int delay, input logic [AW-1:0] ea,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            repeat (delay) @(negedge clk);
            chk({nm, "_addr"}, 32'(rsp_addr), 32'(ea));
            chk({nm, "_d1"}, rsp_data1, e1);
            chk({nm, "_d2"}, rsp_data2, e2);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic fill(input int off);
        for (int i = 0; i < NR; i++) begin
            issue(C_WRITE, AW'(i), '0, DW'(i * 3 + off));
            model_apply(C_WRITE, AW'(i), '0, DW'(i * 3 + off));
        end
        wait_idle();
    endtask

    task automatic dump_check(input int stall_at);
        bit ok;
        issue(C_DUMP, '0, '0, '0);
        for (int i = 0; i < NR; i++) begin
            int n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
            chk("dump_addr", 32'(rsp_addr), 32'(i));
            chk("dump_d1", rsp_data1, model[i]);
            chk("dump_d2", rsp_data2, model[i]);
            if (i == stall_at) begin
                ok = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (!rsp_valid || rsp_addr != AW'(i) || rsp_data1 != model[i] || cmd_ready) ok = 1'b0;
                end
                chk("dump_stall_stable", {31'b0, ok}, 32'd1);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        wait_idle();
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] a, b;
        logic [DW-1:0] d;
        bit            has_rsp;
        logic [DW-1:0] e1, e2;
        int            e_we;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int w0, r0, n, first;
        bit ok;

        tbl[0]  = '{C_WRITE,  5,  0, 32'hDEADBEEF, 0, 0, 0, 1};
        tbl[1]  = '{C_READ2,  5,  0, 0, 1, 32'hDEADBEEF, 32'h0, 0};
        tbl[2]  = '{C_COPY,   5,  9, 0, 0, 0, 0, 1};
        tbl[3]  = '{C_READ2,  9,  5, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        tbl[4]  = '{C_WRITE,  0,  0, 32'h1, 0, 0, 0, ZP ? 0 : 1};
        tbl[5]  = '{C_READ2,  0,  9, 0, 1, ZP ? 32'h0 : 32'h1, 32'hDEADBEEF, 0};
        tbl[6]  = '{C_NOP,    3,  4, 32'h55, 0, 0, 0, 0};
        tbl[7]  = '{C_WRITE, 31,  0, 32'hA5A5A5A5, 0, 0, 0, 1};
        tbl[8]  = '{C_COPY,  31, 31, 0, 0, 0, 0, 1};
        tbl[9]  = '{C_READ2, 31, 31, 0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 0};
        tbl[10] = '{C_COPY,  12,  0, 0, 0, 0, 0, ZP ? 0 : 1};
        tbl[11] = '{C_READ2,  0, 31, 0, 1, 32'h0, 32'hA5A5A5A5, 0};

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
        chk("rst_rsp_bits", {rsp_addr, rsp_data1 | rsp_data2}, '0);
        chk("rst_raddr", 32'({rf_raddr1, rf_raddr2}), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) begin
            w0 = we_cnt;
            r0 = rsp_cnt;
            issue(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].d);
            if (tbl[k].has_rsp) get_rsp($sformatf("tbl%0d", k), k % 3, tbl[k].a, tbl[k].e1, tbl[k].e2);
            else begin
                wait_idle();
                chk($sformatf("tbl%0d_no_rsp", k), 32'(rsp_cnt - r0), 32'd0);
            end
            chk($sformatf("tbl%0d_we_cycles", k), 32'(we_cnt - w0), 32'(tbl[k].e_we));
            model_apply(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].d);
        end

        // WRITE occupies exactly one cycle before the next command can be accepted.
        issue(C_WRITE, 7, 0, 32'h12345678);
        model_apply(C_WRITE, 7, 0, 32'h12345678);
        chk("wr_busy_ready", {31'b0, cmd_ready}, 32'd0);
        chk("wr_we", {31'b0, rf_we}, 32'd1);
        chk("wr_waddr_data", rf_wdata ^ 32'(rf_waddr), 32'h12345678 ^ 32'd7);
        @(posedge clk); #1;
        chk("wr_done_ready", {31'b0, cmd_ready}, 32'd1);
        chk("wr_done_we", {31'b0, rf_we}, 32'd0);

        // Illegal opcode.
        w0 = we_cnt;
        issue(3'd7, 1, 2, 32'hFFFF);
        chk("ill_err", {31'b0, cmd_err}, 32'd1);
        chk("ill_ready", {31'b0, cmd_ready}, 32'd1);
        chk("ill_we", {31'b0, rf_we}, 32'd0);
        @(posedge clk); #1;
        chk("ill_err_pulse", {31'b0, cmd_err}, 32'd0);
        chk("ill_no_write", 32'(we_cnt - w0), 32'd0);

        // CLEAR: one contiguous burst of writes of zero, ascending addresses.
        fill(0);
        first = ZP ? 1 : 0;
        issue(C_CLEAR, '0, '0, '0);
        n = 0;
        ok = 1'b1;
        while (rf_we && n < 100) begin
            if (rf_waddr != AW'(first + n) || rf_wdata != '0) ok = 1'b0;
            n++;
            @(posedge clk); #1;
        end
        model_apply(C_CLEAR, '0, '0, '0);
        chk("clr_we_cycles", 32'(n), 32'(NR - first));
        chk("clr_addr_seq", {31'b0, ok}, 32'd1);
        dump_check(-1);

        // DUMP with consumer stalled at register 7.
        fill(7);
        dump_check(7);

        // Synchronous reset while CLEAR walks: the write of entry 11 completes, 12 onwards untouched.
        fill(0);
        issue(C_CLEAR, '0, '0, '0);
        n = 0;
        while (!(rf_we && rf_waddr == AW'(11)) && n < 100) begin @(posedge clk); #1; n++; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_we", {31'b0, rf_we}, 32'd0);
        chk("rst_mid_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) if (!(ZP && i == 0)) model[i] = '0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) chk($sformatf("rst_mid_reg%0d", i), rf_mem[i], model[i]);

        // Random command traffic against the reference array.
        for (int k = 0; k < 300; k++) begin
            int sel;
            logic [2:0] op;
            logic [AW-1:0] a, b;
            logic [DW-1:0] d;
            sel = $urandom_range(0, 9);
            a = AW'($urandom);
            b = AW'($urandom);
            d = $urandom;
            op = (sel == 0) ? C_NOP : (sel <= 3) ? C_WRITE : (sel <= 6) ? C_READ2 :
                 (sel <= 8) ? C_COPY : 3'(6 + $urandom_range(0, 1));
            w0 = we_cnt;
            issue(op, a, b, d);
            if (op == C_READ2) begin
                get_rsp("rnd_rd", $urandom_range(0, 3), a, model[a], model[b]);
            end else begin
                if (op[2:1] == 2'b11) chk("rnd_err", {31'b0, cmd_err}, 32'd1);
                wait_idle();
                chk("rnd_we_cycles", 32'(we_cnt - w0),
                    (op == C_WRITE) ? 32'((ZP && a == 0) ? 0 : 1) :
                    (op == C_COPY)  ? 32'((ZP && b == 0) ? 0 : 1) : 32'd0);
            end
            model_apply(op, a, b, d);
        end

        dump_check(-1);
        for (int i = 0; i < NR; i++) chk($sformatf("final_reg%0d", i), rf_mem[i], model[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
